// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache, 16 sets of 16-byte lines
module data_cache (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_input_valid,
    input  logic [31:0]  addr,
    input  logic         mem_rw,
    input  logic [31:0]  din,
    output logic         is_ready,
    output logic         is_output_valid,
    output logic         is_hit,
    output logic [31:0]  dout,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [127:0] mem_rdata,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [15:0]  valid_bits;
    logic [15:0]  dirty_bits;
    logic [23:0]  tag_mem  [16];
    logic [127:0] data_mem [16];
    logic [27:0]  miss_line;

    logic [23:0] req_tag;
    logic [3:0]  req_idx;
    logic [1:0]  req_word;
    logic [23:0] miss_tag;
    logic [3:0]  miss_idx;
    logic        lookup_hit;
    logic        lookup_miss;
    logic        unused_addr_bits;

    assign req_tag          = addr[31:8];
    assign req_idx          = addr[7:4];
    assign req_word         = addr[3:2];
    assign miss_tag         = miss_line[27:4];
    assign miss_idx         = miss_line[3:0];
    assign unused_addr_bits = ^addr[1:0];

    assign lookup_hit  = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lookup_miss = is_ready && is_input_valid && !lookup_hit;

    // Outputs are forced quiet while reset is held so nothing leaks out mid-abort.
    always_comb begin
        state_next      = state;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        is_hit          = 1'b0;
        dout            = 32'd0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = 32'd0;
        mem_wdata       = 128'd0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    is_ready = 1'b1;
                    if (is_input_valid) begin
                        if (lookup_hit) begin
                            is_hit          = 1'b1;
                            is_output_valid = 1'b1;
                            if (!mem_rw) begin
                                dout = data_mem[req_idx][{req_word, 5'b0} +: 32];
                            end
                        end else if (valid_bits[req_idx] && dirty_bits[req_idx]) begin
                            state_next = WRITEBACK;
                        end else begin
                            state_next = ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_mem[miss_idx], miss_idx, 4'b0};
                    mem_wdata = data_mem[miss_idx];
                    if (mem_ack) begin
                        state_next = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    mem_req  = 1'b1;
                    mem_addr = {miss_tag, miss_idx, 4'b0};
                    if (mem_ack) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_bits <= 16'd0;
            dirty_bits <= 16'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            state <= state_next;
            if (is_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (lookup_miss) begin
                miss_count <= miss_count + 32'd1;
            end
            if (is_hit && mem_rw) begin
                dirty_bits[req_idx] <= 1'b1;
            end
            if (state == ALLOCATE && mem_ack) begin
                valid_bits[miss_idx] <= 1'b1;
                dirty_bits[miss_idx] <= 1'b0;
            end
        end
    end

    // Tag/data storage is not cleared; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (lookup_miss) begin
                miss_line <= addr[31:4];
            end
            if (is_hit && mem_rw) begin
                data_mem[req_idx][{req_word, 5'b0} +: 32] <= din;
            end
            if (state == ALLOCATE && mem_ack) begin
                data_mem[miss_idx] <= mem_rdata;
                tag_mem[miss_idx]  <= miss_tag;
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache with memory responder and reference model
module tb_data_cache;
    logic         clk = 1'b0;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_rw;
    logic [31:0]  din;
    logic         is_ready, is_output_valid, is_hit;
    logic [31:0]  dout;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    data_cache dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_rw(mem_rw), .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid),
        .is_hit(is_hit), .dout(dout), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 3;

    // Backing memory and the architectural (CPU-visible) view, both word addressed.
    logic [31:0] mem_words [logic [29:0]];
    logic [31:0] arch      [logic [29:0]];

    logic        ref_valid [16];
    logic        ref_dirty [16];
    logic [23:0] ref_tag   [16];
    int          exp_hits, exp_misses;

    int           wb_count = 0;
    int           alloc_count = 0;
    logic [31:0]  last_wb_addr, last_alloc_addr;
    logic [127:0] last_wb_data;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[13:0], 2'b01, w[15:0]} ^ 32'hC3A5_0000;
    endfunction

    function automatic logic [31:0] bk(input logic [29:0] w);
        return mem_words.exists(w) ? mem_words[w] : init_word(w);
    endfunction

    function automatic logic [31:0] av(input logic [29:0] w);
        return arch.exists(w) ? arch[w] : init_word(w);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = 24'd0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        arch.delete();
        foreach (mem_words[k]) arch[k] = mem_words[k];
    endtask

    // Memory responder: acks after lat extra cycles, checks request stability meanwhile.
    initial begin
        logic [31:0]  a;
        logic         we;
        logic [127:0] wd;
        logic [127:0] line;
        bit           abort;
        mem_ack   = 1'b0;
        mem_rdata = 128'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && reset === 1'b0) begin
                a = mem_addr; we = mem_we; wd = mem_wdata; abort = 0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        abort = 1;
                        break;
                    end
                    check("mem_req held", mem_req, 1'b1);
                    check("mem_addr stable", mem_addr, a);
                    check("mem_we stable", mem_we, we);
                    check("mem_wdata stable", mem_wdata, wd);
                    check("busy not ready", is_ready, 1'b0);
                end
                if (!abort) begin
                    if (we) begin
                        line = 128'd0;
                        for (int j = 0; j < 4; j++) line[j*32 +: 32] = av({a[31:4], 2'(j)});
                        check("writeback line", wd, line);
                        wb_count++;
                        last_wb_addr = a;
                        last_wb_data = wd;
                        for (int j = 0; j < 4; j++) mem_words[{a[31:4], 2'(j)}] = wd[j*32 +: 32];
                    end else begin
                        alloc_count++;
                        last_alloc_addr = a;
                        for (int j = 0; j < 4; j++) mem_rdata[j*32 +: 32] = bk({a[31:4], 2'(j)});
                    end
                    mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic do_access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                             output bit first_hit, output int wb_delta);
        logic [3:0]  idx;
        logic [23:0] tag;
        bit          e_hit, e_wb, done;
        int          wb0, n, e_lat;
        idx   = a[7:4];
        tag   = a[31:8];
        e_hit = ref_valid[idx] && ref_tag[idx] == tag;
        e_wb  = !e_hit && ref_valid[idx] && ref_dirty[idx];
        e_lat = e_hit ? 0 : (e_wb ? 2 * lat + 3 : lat + 2);
        wb0   = wb_count;
        done  = 0;
        first_hit = 0;
        @(negedge clk);
        is_input_valid = 1'b1; addr = a; mem_rw = rw; din = d;
        for (n = 0; n < 400; n++) begin
            #1;
            if (n == 0) begin
                first_hit = is_hit;
                check("first-cycle hit", is_hit, e_hit);
            end
            if (is_output_valid) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check("access completed", done, 1'b1);
        check("latency", n, e_lat);
        check("is_hit on completion", is_hit, 1'b1);
        if (!rw) check("read data", dout, av(a[31:2]));
        @(posedge clk);
        #1;
        is_input_valid = 1'b0;
        exp_hits++;
        if (!e_hit) exp_misses++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        if (!e_hit) ref_dirty[idx] = 1'b0;
        if (rw) begin
            ref_dirty[idx] = 1'b1;
            arch[a[31:2]]  = d;
        end
        wb_delta = wb_count - wb0;
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        check("writeback occurred", wb_delta, e_wb);
    endtask

    typedef struct {
        logic        rw;
        logic [31:0] a;
        logic [31:0] d;
        bit          exp_first_hit;
        int          exp_wb;
        int          exp_hits;
        int          exp_misses;
        logic [31:0] exp_alloc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit          fh;
        int          wbd;
        logic        rw;
        logic [31:0] a;
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,    1'b0, 0, 1, 1, 32'h0000_0100};
        vecs[1] = '{1'b0, 32'h0000_0104, 32'h0,    1'b1, 0, 2, 1, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0108, 32'hDEAD, 1'b1, 0, 3, 1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_1108, 32'h0,    1'b0, 1, 4, 2, 32'h0000_1100};
        vecs[4] = '{1'b0, 32'h0000_0108, 32'h0,    1'b0, 0, 5, 3, 32'h0000_0100};

        mem_words[30'h40] = 32'h1;
        mem_words[30'h41] = 32'h2;
        mem_words[30'h42] = 32'h3;
        mem_words[30'h43] = 32'h4;

        reset = 1'b1; is_input_valid = 1'b0; addr = 32'd0; mem_rw = 1'b0; din = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset is_output_valid", is_output_valid, 1'b0);
        check("reset is_hit", is_hit, 1'b0);
        check("reset dout", dout, 32'd0);
        check("reset mem_req", mem_req, 1'b0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 128'd0);
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("idle is_ready", is_ready, 1'b1);
        check("idle mem_req", mem_req, 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_access(vecs[i].rw, vecs[i].a, vecs[i].d, fh, wbd);
            check("vec first hit", fh, vecs[i].exp_first_hit);
            check("vec writeback", wbd, vecs[i].exp_wb);
            check("vec hit_count", hit_count, vecs[i].exp_hits);
            check("vec miss_count", miss_count, vecs[i].exp_misses);
            if (!vecs[i].exp_first_hit) check("vec alloc addr", last_alloc_addr, vecs[i].exp_alloc);
            if (vecs[i].exp_wb != 0) check("vec wb addr", last_wb_addr, 32'h0000_0100);
        end
        check("wb word2", last_wb_data[95:64], 32'hDEAD);

        // Valid-less cycle on a resident address, then a stray ack while idle.
        @(negedge clk);
        addr = 32'h0000_0100; is_input_valid = 1'b0;
        #1;
        check("no-valid is_output_valid", is_output_valid, 1'b0);
        check("no-valid is_hit", is_hit, 1'b0);
        #1;
        mem_rdata = {4{32'hBAD0_BAD0}};
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        check("stray ack mem_req", mem_req, 1'b0);
        check("stray ack is_ready", is_ready, 1'b1);
        do_access(1'b0, 32'h0000_0100, 32'h0, fh, wbd);
        check("stray ack ignored hit", fh, 1'b1);

        lat = 10;
        do_access(1'b0, 32'h0000_03F0, 32'h0, fh, wbd);
        lat = 3;

        // Dirty line at index 0, then reset mid-ALLOCATE of another set.
        do_access(1'b1, 32'h0000_0100, 32'h1234_5678, fh, wbd);
        lat = 6;
        @(negedge clk);
        is_input_valid = 1'b1; addr = 32'h0000_0210; mem_rw = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("alloc mem_req", mem_req, 1'b1);
        check("alloc mem_we", mem_we, 1'b0);
        check("alloc mem_addr", mem_addr, 32'h0000_0210);
        #1 reset = 1'b1; is_input_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("post-abort is_ready", is_ready, 1'b1);
        check("post-abort mem_req", mem_req, 1'b0);
        check("post-abort hit_count", hit_count, 32'd0);
        check("post-abort miss_count", miss_count, 32'd0);
        lat = 3;
        do_access(1'b0, 32'h0000_0100, 32'h0, fh, wbd);
        check("post-reset read misses", fh, 1'b0);
        check("post-reset no writeback", wbd, 0);

        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(1, 5);
            rw  = 1'(($urandom & 32'h3) == 0);
            a   = {22'd0, 2'($urandom_range(0, 3)), 2'd0, 2'($urandom_range(0, 3)), 2'($urandom), 2'b00};
            if (($urandom & 32'h7) == 0) begin
                @(negedge clk);
                addr = a; is_input_valid = 1'b0;
                #1;
                check("rand idle is_output_valid", is_output_valid, 1'b0);
                check("rand idle is_hit", is_hit, 1'b0);
            end
            do_access(rw, a, $urandom, fh, wbd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
